// File: rtl/image_stream_wr_ctrl_pkg.sv
// Shared types, default geometry and helpers for the image stream write controller.
package img_stream_pkg;

  localparam int unsigned IMG_W_DEF     = 32'd752;
  localparam int unsigned IMG_H_DEF     = 32'd480;
  localparam int unsigned FRAME_PIX     = IMG_W_DEF * IMG_H_DEF;
  localparam int unsigned COL_W         = $clog2(IMG_W_DEF);
  localparam int unsigned ROW_W         = $clog2(IMG_H_DEF);
  localparam int unsigned DROP_CNT_W    = 32'd16;
  localparam int unsigned SOF_ERR_CNT_W = 32'd16;
  localparam int unsigned FRAME_CNT_W   = 32'd32;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_e;

  // Index width that still works for a dimension of one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/image_stream_wr_ctrl_if.sv
// Pixel-in / BRAM-write / reader-handshake bundle; master is the controller side.
interface image_stream_wr_ctrl_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 19
);
  logic              in_valid;
  logic              in_sof;
  logic [PIX_W-1:0]  in_data;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              frame_ready;
  logic              rd_bank;
  logic              rd_release;

  modport master (
    input  in_valid, in_sof, in_data, rd_release,
    output wr_en, wr_bank, wr_addr, wr_data, frame_ready, rd_bank
  );

  modport slave (
    output in_valid, in_sof, in_data, rd_release,
    input  wr_en, wr_bank, wr_addr, wr_data, frame_ready, rd_bank
  );
endinterface

// File: rtl/image_stream_wr_ctrl_addr_counter.sv
// Column/row/linear pixel counters; a restart beat is treated as position (0,0).
module img_addr_counter
  import img_stream_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_i,
  input  logic              restart_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  localparam int unsigned CW = idx_w(IMG_W);
  localparam int unsigned RW = idx_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 32'd1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 32'd1);

  logic [CW-1:0]     col_q, col_d, cur_col_s;
  logic [RW-1:0]     row_q, row_d, cur_row_s;
  logic [ADDR_W-1:0] pix_q, pix_d, cur_pix_s;

  // Position of the current beat and the position of the one after it.
  always_comb begin
    cur_col_s = restart_i ? {CW{1'b0}} : col_q;
    cur_row_s = restart_i ? {RW{1'b0}} : row_q;
    cur_pix_s = restart_i ? {ADDR_W{1'b0}} : pix_q;
    addr_o    = cur_pix_s;
    last_o    = (cur_col_s == COL_LAST) && (cur_row_s == ROW_LAST);
    col_d     = col_q;
    row_d     = row_q;
    pix_d     = pix_q;
    if (beat_i && last_o) begin
      col_d = {CW{1'b0}};
      row_d = {RW{1'b0}};
      pix_d = {ADDR_W{1'b0}};
    end else if (beat_i && (cur_col_s == COL_LAST)) begin
      col_d = {CW{1'b0}};
      row_d = cur_row_s + RW'(1);
      pix_d = cur_pix_s + ADDR_W'(1);
    end else if (beat_i) begin
      col_d = cur_col_s + CW'(1);
      row_d = cur_row_s;
      pix_d = cur_pix_s + ADDR_W'(1);
    end else begin
      pix_d = pix_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= {CW{1'b0}};
      row_q <= {RW{1'b0}};
      pix_q <= {ADDR_W{1'b0}};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      pix_q <= pix_d;
    end
  end

endmodule

// File: rtl/image_stream_wr_ctrl.sv
// Pixel-stream write controller: sof resync, linear BRAM addressing, 1/2-bank frame handoff.
// frame_cnt and sof_err_cnt are only built when IMG_WR_STATS_EN is defined.
module image_stream_wr_ctrl
  import img_stream_pkg::*;
#(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned IMG_W     = IMG_W_DEF,
  parameter int unsigned IMG_H     = IMG_H_DEF,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned NUM_BANKS = 2
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  image_stream_wr_ctrl_if.master   bus,
  output logic                     frame_done,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  output logic [SOF_ERR_CNT_W-1:0] sof_err_cnt,
  output logic [FRAME_CNT_W-1:0]   frame_cnt
);
  localparam logic TWO_BANKS = (NUM_BANKS == 32'd2);

  wr_state_e             state_q, state_d;
  logic                  frame_ready_q, frame_ready_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  frame_done_q, frame_done_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PIX_W-1:0]      pix_s;
  logic [ADDR_W-1:0]     addr_s;
  logic sof_s, bank_free_s, accept_sof_s, wr_en_s, restart_s, last_s, end_s, held_s;

  assign sof_s        = bus.in_valid && bus.in_sof;
  assign bank_free_s  = TWO_BANKS || !frame_ready_q;
  assign accept_sof_s = sof_s && (state_q != WRITE) && bank_free_s;
  assign wr_en_s      = bus.in_valid && ((state_q == WRITE) || accept_sof_s);
  assign restart_s    = wr_en_s && bus.in_sof;
  assign end_s        = wr_en_s && last_s;
  // A release in the commit cycle is applied first, so it frees the held bank.
  assign held_s       = frame_ready_q && !bus.rd_release;
  assign pix_s        = bus.in_data;

  img_addr_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .beat_i    (wr_en_s),
    .restart_i (restart_s),
    .addr_o    (addr_s),
    .last_o    (last_s)
  );

  // Next state, bank bookkeeping and drop counting.
  always_comb begin
    state_d       = state_q;
    frame_ready_d = frame_ready_q && !bus.rd_release;
    rd_bank_d     = rd_bank_q;
    wr_bank_d     = wr_bank_q;
    frame_done_d  = end_s;
    drop_cnt_d    = drop_cnt_q;
    case (state_q)
      SYNC, DROP: begin
        if (sof_s && !bank_free_s) begin
          state_d    = DROP;
          drop_cnt_d = sat_inc16(drop_cnt_q);
        end else if (accept_sof_s) begin
          state_d = end_s ? SYNC : WRITE;
        end else begin
          state_d = state_q;
        end
      end
      WRITE: begin
        if (end_s) begin
          state_d = SYNC;
        end else begin
          state_d = WRITE;
        end
      end
      default: state_d = SYNC;
    endcase
    if (end_s && TWO_BANKS && held_s) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end else if (end_s) begin
      frame_ready_d = 1'b1;
      rd_bank_d     = TWO_BANKS ? wr_bank_q : 1'b0;
      wr_bank_d     = TWO_BANKS ? !wr_bank_q : 1'b0;
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  // Control and bookkeeping registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= SYNC;
      frame_ready_q <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_bank_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      drop_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      frame_ready_q <= frame_ready_d;
      rd_bank_q     <= rd_bank_d;
      wr_bank_q     <= wr_bank_d;
      frame_done_q  <= frame_done_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef IMG_WR_STATS_EN
  logic [SOF_ERR_CNT_W-1:0] sof_err_cnt_q, sof_err_cnt_d;
  logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  // Short-frame and completed-frame statistics.
  always_comb begin
    sof_err_cnt_d = ((state_q == WRITE) && sof_s) ? sat_inc16(sof_err_cnt_q) : sof_err_cnt_q;
    frame_cnt_d   = end_s ? frame_cnt_q + 32'd1 : frame_cnt_q;
  end

  // Statistics registers.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sof_err_cnt_q <= 16'd0;
      frame_cnt_q   <= 32'd0;
    end else begin
      sof_err_cnt_q <= sof_err_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign sof_err_cnt = sof_err_cnt_q;
  assign frame_cnt   = frame_cnt_q;
`else
  assign sof_err_cnt = 16'd0;
  assign frame_cnt   = 32'd0;
`endif

  assign bus.wr_en       = wr_en_s;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.wr_addr     = addr_s;
  assign bus.wr_data     = pix_s;
  assign bus.frame_ready = frame_ready_q;
  assign bus.rd_bank     = rd_bank_q;
  assign frame_done      = frame_done_q;
  assign drop_cnt        = drop_cnt_q;

endmodule
